seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the lab board.
- Takes a 16-bit hex value plus per-digit enables and decimal points.
- Shares the single segment bus between four digits by cycling anodes.
- Inserts a blanking guard at each digit slot to suppress ghosting.
- Commits new display data only at frame boundaries, using a load/ack handshake so updates never tear mid-frame.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_scan_ctrl_if.sv | 13 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active-low, bit order gfedcba.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Entry 15 first so that HEX_SEG[n] yields the pattern for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_t;

    // True when the digit and every digit to its left hold zero; digit 0 always shows.
    function automatic logic lz_hidden(input logic [15:0] v, input digit_idx_t idx,
                                       input logic lz);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(idx) && v[4*i +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        return lz && (idx != 2'd0) && all_zero;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/ack handshake bus carrying new display data into the scan controller.
interface seg_scan_ctrl_if;

    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load_ack;

    modport master (output load, value, dp_in, digit_en, input load_ack);
    modport slave  (input load, value, dp_in, digit_en, output load_ack);

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with per-slot blanking guard and
// frame-aligned commit of new display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus,
    input  logic            lz_blank,
    output logic [3:0]      an,
    output logic [6:0]      seg,
    output logic            dp,
    output logic            frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam slot_state_t SLOT_FIRST = (BLANK_CYCLES > 0) ? SLOT_BLANK : SLOT_DRIVE;

    logic [CNT_W-1:0] slot_cnt;
    digit_idx_t       idx;
    slot_state_t      state, state_nxt;
    disp_t            disp, pend, incoming;
    logic             pend_valid;
    logic             slot_end, boundary, lit;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    assign slot_end = (slot_cnt == SLOT_LAST);
    assign boundary = slot_end && (idx == 2'd3);
    assign incoming = '{value: bus.value, dp: bus.dp_in, en: bus.digit_en};
    assign nibble   = disp.value[{idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lit       = 1'b0;
        an_nxt    = AN_OFF;
        seg_nxt   = SEG_BLANK;
        dp_nxt    = 1'b1;
        case (state)
            SLOT_BLANK: if (slot_cnt == BLANK_LAST) state_nxt = SLOT_DRIVE;
            SLOT_DRIVE: if (slot_end) state_nxt = SLOT_FIRST;
            default:    state_nxt = SLOT_FIRST;
        endcase
        lit = (state == SLOT_DRIVE) && disp.en[idx] && !lz_hidden(disp.value, idx, lz_blank);
        if (lit) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = dec_seg;
            dp_nxt  = ~disp.dp[idx];
        end
    end

    // A load arriving on the boundary cycle itself skips the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (bus.load) begin
                disp <= incoming;
            end else if (pend_valid) begin
                disp <= pend;
            end
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pend       <= incoming;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an           <= AN_OFF;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
            bus.load_ack <= 1'b0;
        end else begin
            an           <= an_nxt;
            seg          <= seg_nxt;
            dp           <= dp_nxt;
            frame_done   <= boundary;
            bus.load_ack <= boundary && (pend_valid || bus.load);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: fixed vectors plus randomized traffic against a
// cycle-count reference model, with REFRESH_DIV=8 and BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * RD;

    logic       clk;
    logic       rst_n;
    logic       lz_blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      en;
        logic [3:0]      dpm;
        logic            lz;
        logic [3:0][3:0] an_x;
        logic [3:0][6:0] seg_x;
        logic [3:0]      dp_x;
    } tv_t;

    int          n_vec;
    int          n_err;
    logic        chk_en;
    int          m_cyc;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_en, p_en, m_dp, p_dp;
    logic        m_pv;
    logic [11:0] exp_vis;
    logic        exp_fd, exp_ack;

    function automatic logic [6:0] hex_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected {an,seg,dp} for the cycle counted c since reset release.
    function automatic logic [11:0] model_vis(input int c, input logic [15:0] v,
                                              input logic [3:0] en, input logic [3:0] dpm,
                                              input logic lz);
        int d, s;
        logic [15:0] upper;
        logic [3:0]  an_e;
        d = (c / RD) % 4;
        s = c % RD;
        upper = v >> (4 * d);
        an_e = ~(4'b0001 << d);
        if (s < BL || !en[d] || (lz && d > 0 && upper == 16'h0)) return 12'hFFF;
        return {an_e, hex_ref(upper[3:0]), ~dpm[d]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 0;
            m_val   <= '0;
            m_en    <= '0;
            m_dp    <= '0;
            p_val   <= '0;
            p_en    <= '0;
            p_dp    <= '0;
            m_pv    <= 1'b0;
            exp_vis <= 12'hFFF;
            exp_fd  <= 1'b0;
            exp_ack <= 1'b0;
        end else begin
            exp_vis <= model_vis(m_cyc, m_val, m_en, m_dp, lz_blank);
            exp_fd  <= (m_cyc % FRAME) == FRAME - 1;
            exp_ack <= ((m_cyc % FRAME) == FRAME - 1) && (m_pv || bus.load);
            if ((m_cyc % FRAME) == FRAME - 1) begin
                if (bus.load) begin
                    m_val <= bus.value;
                    m_en  <= bus.digit_en;
                    m_dp  <= bus.dp_in;
                end else if (m_pv) begin
                    m_val <= p_val;
                    m_en  <= p_en;
                    m_dp  <= p_dp;
                end
                m_pv <= 1'b0;
            end else if (bus.load) begin
                p_val <= bus.value;
                p_en  <= bus.digit_en;
                p_dp  <= bus.dp_in;
                m_pv  <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_model();
        if (!chk_en) return;
        n_vec++;
        if ({an, seg, dp} !== exp_vis || frame_done !== exp_fd || bus.load_ack !== exp_ack) begin
            n_err++;
            $display("[TB] FAIL model @%0t: got an=%h seg=%h dp=%b fd=%b ack=%b, required an=%h seg=%h dp=%b fd=%b ack=%b",
                     $time, an, seg, dp, frame_done, bus.load_ack,
                     exp_vis[11:8], exp_vis[7:1], exp_vis[0], exp_fd, exp_ack);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (frame_done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL frame_done timeout: got 0, required 1");
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpm);
        bus.value    = v;
        bus.digit_en = en;
        bus.dp_in    = dpm;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    tv_t tv [6];

    initial begin
        int pos, acks, n;
        logic lit_seen;
        logic [31:0] rv;

        tv[0] = '{16'h12AF, 4'hF, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
        tv[1] = '{16'h0050, 4'hF, 4'h0, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE},
                  {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        tv[2] = '{16'h0000, 4'hF, 4'h0, 1'b1, {4'hF, 4'hF, 4'hF, 4'hE},
                  {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        tv[3] = '{16'h3C9E, 4'b0101, 4'b0001, 1'b0, {4'hF, 4'hB, 4'hF, 4'hE},
                  {7'h7F, 7'h46, 7'h7F, 7'h06}, 4'b1110};
        tv[4] = '{16'h8476, 4'hF, 4'b1010, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h00, 7'h19, 7'h78, 7'h02}, 4'b0101};
        tv[5] = '{16'h0D0B, 4'hF, 4'h0, 1'b1, {4'hF, 4'hB, 4'hD, 4'hE},
                  {7'h7F, 7'h21, 7'h40, 7'h03}, 4'hF};

        n_vec = 0;
        n_err = 0;
        chk_en = 1'b0;
        lz_blank = 1'b0;
        bus.load = 1'b0;
        bus.value = '0;
        bus.digit_en = '0;
        bus.dp_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check_output("reset an", {12'h0, an}, 16'h000F);
        check_output("reset seg", {9'h0, seg}, 16'h007F);
        rst_n = 1'b1;

        // Idle after reset: one frame_done every 32 cycles, display dark.
        wait_frame();
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 2 * FRAME);
        check_output("frame period", n[15:0], 16'(FRAME));

        for (int i = 0; i < 6; i++) begin
            lz_blank = tv[i].lz;
            repeat ($urandom_range(1, FRAME)) tick();
            apply_stimulus(tv[i].val, tv[i].en, tv[i].dpm);
            wait_frame();
            check_output($sformatf("vec%0d ack", i), {15'h0, bus.load_ack}, 16'h0001);
            pos = 0;
            for (int d = 0; d < 4; d++) begin
                repeat (RD * d + 5 - pos) tick();
                pos = RD * d + 5;
                check_output($sformatf("vec%0d d%0d an", i, d), {12'h0, an}, {12'h0, tv[i].an_x[d]});
                check_output($sformatf("vec%0d d%0d seg", i, d), {9'h0, seg}, {9'h0, tv[i].seg_x[d]});
                check_output($sformatf("vec%0d d%0d dp", i, d), {15'h0, dp}, {15'h0, tv[i].dp_x[d]});
            end
        end

        // Two loads in one frame: latest wins, single acknowledge.
        lz_blank = 1'b0;
        wait_frame();
        repeat (3) tick();
        apply_stimulus(16'h1111, 4'hF, 4'h0);
        tick();
        apply_stimulus(16'h2222, 4'hF, 4'h0);
        acks = 0;
        for (int k = 0; k < FRAME + 4; k++) begin
            tick();
            if (bus.load_ack === 1'b1) acks++;
        end
        check_output("b2b ack count", acks[15:0], 16'h0001);
        wait_frame();
        repeat (5) tick();
        check_output("b2b seg", {9'h0, seg}, 16'h0024);

        // Load exactly on the boundary cycle commits at once.
        wait_frame();
        repeat (FRAME - 1) tick();
        apply_stimulus(16'hBEEF, 4'hF, 4'h0);
        check_output("bnd frame_done", {15'h0, frame_done}, 16'h0001);
        check_output("bnd ack", {15'h0, bus.load_ack}, 16'h0001);
        repeat (5) tick();
        check_output("bnd seg", {9'h0, seg}, 16'h000E);

        // Reset in the middle of a lit slot goes dark at once and clears the display.
        check_output("pre-reset an", {12'h0, an}, 16'h000E);
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset an", {12'h0, an}, 16'h000F);
        check_output("midreset seg", {9'h0, seg}, 16'h007F);
        check_output("midreset dp", {15'h0, dp}, 16'h0001);
        repeat (3) tick();
        rst_n = 1'b1;
        lit_seen = 1'b0;
        for (int k = 0; k < FRAME + 2; k++) begin
            tick();
            if (an !== 4'hF) lit_seen = 1'b1;
        end
        check_output("dark after reset", {15'h0, lit_seen}, 16'h0000);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 30 * FRAME; k++) begin
            if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 15) == 0) begin
                rv = $urandom;
                if ($urandom_range(0, 1) == 1) rv = rv >> (4 * $urandom_range(1, 4));
                bus.value    = rv[15:0];
                bus.digit_en = 4'($urandom);
                bus.dp_in    = 4'($urandom);
                bus.load     = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
